// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite definitions for the SRAM responder and the bus master.
// Contents: HTRANS/HSIZE/HBURST/HRESP encodings, the responder FSM state
// type and a byte-lane decode helper used by the responder.
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  // HSIZE encodings (only byte/halfword/word are supported by the SRAM)
  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  // HBURST encodings
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  // HRESP encodings
  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // Responder data-phase FSM
  typedef enum logic [1:0] {
    S_READY = 2'b00,
    S_WAIT  = 2'b01,
    S_ERR1  = 2'b10,
    S_ERR2  = 2'b11
  } slave_state_e;

  // Little-endian byte-lane enables for a transfer of the given size.
  // Unsupported sizes return no lanes.
  function automatic logic [3:0] byte_enable(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if
// AHB-Lite bus bundle between a master/decoder and the SRAM responder.
// Address/control: HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT,
// HMASTLOCK, HREADY (bus-level ready). Data: HWDATA (to slave),
// HRDATA (from slave). Response: HREADYOUT, HRESP (from slave).
interface ahb_sram_slave_if;
  import ahb_pkg::*;

  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK,
           HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK,
           HWDATA,
    input  HREADY, HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem
// MEM_WORDS x 32 storage with per-byte write enables.
// Ports: clk; wr_be/wr_idx/wr_data form the synchronous write port;
// rd_idx/rd_data form the asynchronous read port (registered by the parent).
// Contents are not reset.
module ahb_sram_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [MEM_WORDS];

  // Byte-masked write: only enabled lanes of the addressed word change
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// AHB-Lite responder terminating transfers into an internal word SRAM.
// Supports byte/halfword/word accesses, WAIT_STATES extra data-phase
// cycles on OKAY transfers, and the two-cycle ERROR response for bad
// sizes, misaligned or out-of-range addresses.
// Ports: HCLK, HRESETn (async, active-low), bus (slave modport of
// ahb_sram_slave_if carrying all AHB address/data/response signals).
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_sram_slave_if.slave bus
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

  slave_state_e     state, next_state;
  logic [3:0]       wait_cnt, wait_cnt_next;
  logic             hreadyout, hresp;

  logic [31:0]      offset;
  logic             accept, addr_err, accept_ok, accept_err;
  logic [IDX_W-1:0] acc_idx;
  logic [3:0]       acc_be;

  logic [3:0]       pend_be;
  logic [IDX_W-1:0] pend_idx;
  logic [3:0]       commit_be;

  logic [31:0]      mem_rdata, rd_merged, hrdata_q;

  logic             unused_ok;

  // Address-phase decode. The offset wraps at 32 bits so addresses below
  // BASE_ADDR become huge offsets and fail the range check.
  assign offset     = bus.HADDR - BASE_ADDR;
  assign accept     = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign acc_idx    = offset[IDX_W+1:2];
  assign acc_be     = byte_enable(bus.HSIZE, bus.HADDR[1:0]);
  assign accept_ok  = accept & ~addr_err;
  assign accept_err = accept & addr_err;

  // Error classification of the transfer being offered
  always_comb begin
    addr_err = 1'b0;
    if (bus.HSIZE > SIZE_WORD) addr_err = 1'b1;
    if ((bus.HSIZE == SIZE_HALF) && bus.HADDR[0]) addr_err = 1'b1;
    if ((bus.HSIZE == SIZE_WORD) && (bus.HADDR[1:0] != 2'b00)) addr_err = 1'b1;
    if (offset >= MEM_BYTES) addr_err = 1'b1;
  end

  // FSM state and wait counter registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_READY;
      wait_cnt <= 4'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state and response outputs. A new accept is only possible when
  // HREADYOUT is high, i.e. from S_READY or S_ERR2.
  always_comb begin
    next_state    = state;
    wait_cnt_next = wait_cnt;
    hreadyout     = 1'b1;
    hresp         = RESP_OKAY;
    case (state)
      S_READY, S_ERR2: begin
        hresp      = (state == S_ERR2) ? RESP_ERROR : RESP_OKAY;
        next_state = S_READY;
        if (accept_err) begin
          next_state = S_ERR1;
        end else if (accept_ok && (WAIT_STATES > 0)) begin
          next_state    = S_WAIT;
          wait_cnt_next = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        hreadyout     = 1'b0;
        wait_cnt_next = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) next_state = S_READY;
      end
      S_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = RESP_ERROR;
        next_state = S_ERR2;
      end
      default: next_state = S_READY;
    endcase
  end

  // Pending write of the current data phase. It is replaced only on the
  // edge that ends the data phase; a reset drops it before it commits.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_be  <= 4'b0000;
      pend_idx <= '0;
    end else if (hreadyout) begin
      pend_be  <= (accept_ok && bus.HWRITE) ? acc_be : 4'b0000;
      pend_idx <= acc_idx;
    end
  end

  assign commit_be = hreadyout ? pend_be : 4'b0000;

  ahb_sram_mem #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk     (HCLK),
    .wr_be   (commit_be),
    .wr_idx  (pend_idx),
    .wr_data (bus.HWDATA),
    .rd_idx  (acc_idx),
    .rd_data (mem_rdata)
  );

  // A read accepted on the edge where a write to the same word commits
  // would otherwise see pre-write memory, so the committing lanes are
  // taken straight from HWDATA.
  always_comb begin
    rd_merged = mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (commit_be[b] && (pend_idx == acc_idx)) begin
        rd_merged[8*b +: 8] = bus.HWDATA[8*b +: 8];
      end
    end
  end

  // Read data register: loaded only by accepted OKAY reads, held otherwise
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hrdata_q <= 32'h0;
    end else if (accept_ok && !bus.HWRITE) begin
      hrdata_q <= rd_merged;
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata_q;

  // Burst type, protection and lock carry no meaning for this memory
  assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
// Self-checking bench for ahb_sram_slave. Three instances with 0, 3 and 2
// wait states share one pipelined stimulus driver; only the selected
// instance sees HSEL. Vector tables hold address-phase stimulus and the
// expected data-phase response of each transfer.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          WORDS = 64;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] off;
    logic [31:0] wdata;
    int          exp_waits;
    logic        exp_resp;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        HCLK;
  logic        HRESETn;
  logic        t_sel;
  logic [31:0] t_addr;
  logic        t_write;
  logic [1:0]  t_trans;
  logic [2:0]  t_size;
  logic [31:0] t_wdata;
  int          cur;
  logic        rdy_m, resp_m;
  logic [31:0] rdata_m;

  int          tests_run;
  int          tests_failed;
  vec_t        vecs[$];
  string       tag;

  ahb_sram_slave_if bus0();
  ahb_sram_slave_if bus1();
  ahb_sram_slave_if bus2();

  // Clock generation
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Shared drive, gated per instance by HSEL
  assign bus0.HSEL = t_sel && (cur == 0);
  assign bus1.HSEL = t_sel && (cur == 1);
  assign bus2.HSEL = t_sel && (cur == 2);
  assign bus0.HADDR = t_addr;   assign bus1.HADDR = t_addr;   assign bus2.HADDR = t_addr;
  assign bus0.HWRITE = t_write; assign bus1.HWRITE = t_write; assign bus2.HWRITE = t_write;
  assign bus0.HTRANS = t_trans; assign bus1.HTRANS = t_trans; assign bus2.HTRANS = t_trans;
  assign bus0.HSIZE = t_size;   assign bus1.HSIZE = t_size;   assign bus2.HSIZE = t_size;
  assign bus0.HWDATA = t_wdata; assign bus1.HWDATA = t_wdata; assign bus2.HWDATA = t_wdata;
  assign bus0.HBURST = BURST_SINGLE; assign bus1.HBURST = BURST_INCR; assign bus2.HBURST = BURST_SINGLE;
  assign bus0.HPROT = 4'b0011;  assign bus1.HPROT = 4'b0011;  assign bus2.HPROT = 4'b0011;
  assign bus0.HMASTLOCK = 1'b0; assign bus1.HMASTLOCK = 1'b0; assign bus2.HMASTLOCK = 1'b0;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;

  ahb_sram_slave #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(0))
    dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0));
  ahb_sram_slave #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(3))
    dut3 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1));
  ahb_sram_slave #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(2))
    dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2));

  // Response of the currently selected instance
  always_comb begin
    case (cur)
      1:       begin rdy_m = bus1.HREADYOUT; resp_m = bus1.HRESP; rdata_m = bus1.HRDATA; end
      2:       begin rdy_m = bus2.HREADYOUT; resp_m = bus2.HRESP; rdata_m = bus2.HRDATA; end
      default: begin rdy_m = bus0.HREADYOUT; resp_m = bus0.HRESP; rdata_m = bus0.HRDATA; end
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one address phase (plus the HWDATA of the previous transfer) and
  // hold it until the selected slave is ready; reports what the previous
  // data phase looked like.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans,
                               input logic wr, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output int waits, output logic resp_first,
                               output logic resp_last, output logic [31:0] rdata);
    logic done;
    t_sel = sel; t_trans = trans; t_write = wr; t_size = size;
    t_addr = addr; t_wdata = wdata;
    waits = 0; done = 1'b0;
    resp_first = 1'b0; resp_last = 1'b0; rdata = 32'h0;
    for (int n = 0; n < 32 && !done; n++) begin
      @(negedge HCLK);
      if (n == 0) resp_first = resp_m;
      if (rdy_m) begin
        done = 1'b1;
        resp_last = resp_m;
        rdata = rdata_m;
      end else begin
        waits++;
        @(posedge HCLK); #1;
      end
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s ready_timeout: HREADYOUT stayed 0, expected 1", tag);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic addVec(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] off,
                        input logic [31:0] wdata, input int exp_waits,
                        input logic exp_resp, input logic chk_rdata,
                        input logic [31:0] exp_rdata);
    vec_t v;
    v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.off = off;
    v.wdata = wdata; v.exp_waits = exp_waits; v.exp_resp = exp_resp;
    v.chk_rdata = chk_rdata; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endtask

  // Issue the table back-to-back, then one IDLE to close the last data phase
  task automatic runVectors();
    int          waits;
    logic        rf, rl;
    logic [31:0] rd;
    vec_t        p;
    for (int i = 0; i <= vecs.size(); i++) begin
      if (i < vecs.size()) begin
        applyStimulus(vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].size,
                      BASE + vecs[i].off, (i > 0) ? vecs[i-1].wdata : 32'h0,
                      waits, rf, rl, rd);
      end else begin
        applyStimulus(1'b0, TRANS_IDLE, 1'b0, SIZE_WORD, BASE,
                      vecs[i-1].wdata, waits, rf, rl, rd);
      end
      if (i > 0) begin
        p = vecs[i-1];
        checkOutput($sformatf("%s v%0d waits", tag, i-1), 32'(waits), 32'(p.exp_waits));
        checkOutput($sformatf("%s v%0d resp_first", tag, i-1), 32'(rf), 32'(p.exp_resp));
        checkOutput($sformatf("%s v%0d resp_last", tag, i-1), 32'(rl), 32'(p.exp_resp));
        if (p.chk_rdata)
          checkOutput($sformatf("%s v%0d rdata", tag, i-1), rd, p.exp_rdata);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    cur = 0; tag = "reset";
    t_sel = 1'b0; t_trans = TRANS_IDLE; t_write = 1'b0; t_size = SIZE_WORD;
    t_addr = BASE; t_wdata = 32'h0;
    HRESETn = 1'b0;
    #7;
    checkOutput("reset hreadyout", 32'(rdy_m), 32'd1);
    checkOutput("reset hresp", 32'(resp_m), 32'd0);
    checkOutput("reset hrdata", rdata_m, 32'h0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Zero wait states: lanes, forwarding, errors, idle/busy/unselected
    cur = 0; tag = "ws0";
    vecs.delete();
    addVec(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0);
    addVec(1, TRANS_IDLE,   0, SIZE_WORD, 32'h10, 32'hFFFF_FFFF, 0, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h10, 32'h0,        0, 0, 1, 32'hDEADBEEF);
    addVec(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h20, 32'h11223344, 0, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 1, SIZE_BYTE, 32'h22, 32'h55AA5555, 0, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h20, 32'h0,        0, 0, 1, 32'h11AA3344);
    addVec(1, TRANS_NONSEQ, 1, SIZE_HALF, 32'h20, 32'hCAFEBEEF, 0, 0, 0, 32'h0);
    addVec(1, TRANS_IDLE,   0, SIZE_WORD, 32'h20, 32'h0,        0, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h20, 32'h0,        0, 0, 1, 32'h11AABEEF);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h02, 32'h0,        1, 1, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 1, 3'b011,    32'h10, 32'hFFFF_FFFF, 1, 1, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'(4*WORDS), 32'hFFFF_FFFF, 1, 1, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1, 1, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h10, 32'h0,        0, 0, 1, 32'hDEADBEEF);
    addVec(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h40, 32'h5555AAAA, 0, 0, 0, 32'h0);
    addVec(1, TRANS_SEQ,    0, SIZE_WORD, 32'h40, 32'h0,        0, 0, 1, 32'h5555AAAA);
    addVec(1, TRANS_BUSY,   1, SIZE_WORD, 32'h10, 32'hBAD0BAD0, 0, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_BYTE, 32'h13, 32'h0,        0, 0, 1, 32'hDEADBEEF);
    addVec(0, TRANS_NONSEQ, 1, SIZE_WORD, 32'h10, 32'h0BADF00D, 0, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h10, 32'h0,        0, 0, 1, 32'hDEADBEEF);
    addVec(1, TRANS_NONSEQ, 0, SIZE_HALF, 32'h21, 32'h0,        1, 1, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 1, SIZE_HALF, 32'h22, 32'h12349999, 0, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h20, 32'h0,        0, 0, 1, 32'h1234BEEF);
    runVectors();

    // Three wait states; the next address is held through the extension
    cur = 1; tag = "ws3";
    vecs.delete();
    addVec(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h10, 32'h01020304, 3, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h10, 32'h0,        3, 0, 1, 32'h01020304);
    addVec(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h14, 32'h0A0B0C0D, 3, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h14, 32'h0,        3, 0, 1, 32'h0A0B0C0D);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h02, 32'h0,        1, 1, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h10, 32'h0,        3, 0, 1, 32'h01020304);
    addVec(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h80, 32'h600DF00D, 3, 0, 0, 32'h0);
    runVectors();

    // Two wait states: write immediately followed by read of the same word
    cur = 2; tag = "ws2";
    vecs.delete();
    addVec(1, TRANS_NONSEQ, 1, SIZE_WORD, 32'h40, 32'h5555AAAA, 2, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h40, 32'h0,        2, 0, 1, 32'h5555AAAA);
    addVec(1, TRANS_IDLE,   0, SIZE_WORD, 32'h40, 32'h0,        0, 0, 0, 32'h0);
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h40, 32'h0,        2, 0, 1, 32'h5555AAAA);
    runVectors();

    // Reset during the wait phase of a write drops the write
    cur = 1; tag = "rst";
    t_sel = 1'b1; t_trans = TRANS_NONSEQ; t_write = 1'b1; t_size = SIZE_WORD;
    t_addr = BASE + 32'h80; t_wdata = 32'h0;
    @(posedge HCLK); #1;
    t_trans = TRANS_IDLE; t_wdata = 32'hBADBAD00;
    @(negedge HCLK);
    checkOutput("rst pre hreadyout", 32'(rdy_m), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    checkOutput("rst async hreadyout", 32'(rdy_m), 32'd1);
    checkOutput("rst async hresp", 32'(resp_m), 32'd0);
    checkOutput("rst async hrdata", rdata_m, 32'h0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    vecs.delete();
    addVec(1, TRANS_NONSEQ, 0, SIZE_WORD, 32'h80, 32'h0, 3, 0, 1, 32'h600DF00D);
    runVectors();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
